// File: rtl/booth_r4_mul_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// Holds the FSM state, the Booth digit encoding and the digit-count function.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } booth_state_e;

   typedef enum logic [2:0] {
      PP_ZERO,
      PP_POS1,
      PP_POS2,
      PP_NEG1,
      PP_NEG2
   } booth_digit_e;

   // One digit per bit pair, plus one extra digit for the two extension bits.
   function automatic int booth_steps(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_mul_if.sv
// Request/acknowledge bundle between a caller and booth_r4_mul.
// The caller holds M1, M2 and SIGNED stable while REQ is high.
interface booth_r4_mul_if #(
   parameter int WIDTH = 24
);
   logic                 REQ;
   logic [WIDTH-1:0]     M1;
   logic [WIDTH-1:0]     M2;
   logic                 SIGNED;
   logic [2*WIDTH-1:0]   RES;
   logic                 ACK;
   logic                 BUSY;

   modport master (
      output REQ, M1, M2, SIGNED,
      input  RES, ACK, BUSY
   );

   modport slave (
      input  REQ, M1, M2, SIGNED,
      output RES, ACK, BUSY
   );
endinterface

// File: rtl/booth_r4_mul_recode.sv
// Combinational radix-4 Booth recoder.
// Turns a 3-bit multiplier window into a digit and the matching signed partial product of X.
module booth_r4_recode
   import booth_pkg::*;
#(
   parameter int WIDTH = 24
)
(
   input  logic [2:0]       i_win,
   input  logic [WIDTH+1:0] i_x,
   output booth_digit_e     o_digit,
   output logic [WIDTH+2:0] o_pp
);

   logic [WIDTH+2:0] w_x1;
   logic [WIDTH+2:0] w_x2;

   assign w_x1 = {i_x[WIDTH+1], i_x};
   assign w_x2 = {i_x, 1'b0};

   always_comb begin
      o_digit = PP_ZERO;
      case (i_win)
         3'b001, 3'b010: o_digit = PP_POS1;
         3'b011:         o_digit = PP_POS2;
         3'b100:         o_digit = PP_NEG2;
         3'b101, 3'b110: o_digit = PP_NEG1;
         default:        o_digit = PP_ZERO;
      endcase
   end

   always_comb begin
      o_pp = '0;
      case (o_digit)
         PP_POS1: o_pp = w_x1;
         PP_POS2: o_pp = w_x2;
         PP_NEG1: o_pp = -w_x1;
         PP_NEG2: o_pp = -w_x2;
         default: o_pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_r4_mul.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, with REQ/ACK handshake,
// runtime signed/unsigned mode and optional single-cycle retirement of zero operands.
module booth_r4_mul
   import booth_pkg::*;
#(
   parameter int WIDTH      = 24,
   parameter bit EARLY_ZERO = 1'b1
)
(
   input  logic           CLK,
   input  logic           RSTn,
   booth_r4_mul_if.slave  io_bus
);

   localparam int N  = booth_steps(WIDTH);
   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * WIDTH + 2;

   booth_state_e      r_state;
   booth_state_e      w_state_next;
   logic [WIDTH+1:0]  r_x;
   logic [WIDTH+1:0]  r_y;
   logic              r_yprev;
   logic              r_zero;
   logic [PW-1:0]     r_acc;
   logic [CW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] r_res;

   booth_digit_e      w_digit;
   logic [WIDTH+2:0]  w_pp;
   logic [PW-1:0]     w_pp_ext;
   logic [PW-1:0]     w_addend;
   logic [PW-1:0]     w_acc_next;
   logic              w_last;
   logic              w_early;

   booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
      .i_win   ({r_y[1], r_y[0], r_yprev}),
      .i_x     (r_x),
      .o_digit (w_digit),
      .o_pp    (w_pp)
   );

   // The multiplier shifts right two bits per step, so the partial product is weighted by 4^cnt.
   assign w_pp_ext   = {{(PW-WIDTH-3){w_pp[WIDTH+2]}}, w_pp};
   assign w_addend   = (w_digit == PP_ZERO) ? '0 : (w_pp_ext << {r_cnt, 1'b0});
   assign w_acc_next = r_acc + w_addend;
   assign w_last     = (r_cnt == CW'(N - 1));
   assign w_early    = EARLY_ZERO && r_zero;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (io_bus.REQ) w_state_next = CALC;
         CALC:    if (w_early || w_last) w_state_next = DONE;
         DONE:    if (!io_bus.REQ) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_x     <= '0;
         r_y     <= '0;
         r_yprev <= 1'b0;
         r_zero  <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_res   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (io_bus.REQ) begin
                  r_x     <= io_bus.SIGNED ? {{2{io_bus.M1[WIDTH-1]}}, io_bus.M1} : {2'b00, io_bus.M1};
                  r_y     <= io_bus.SIGNED ? {{2{io_bus.M2[WIDTH-1]}}, io_bus.M2} : {2'b00, io_bus.M2};
                  r_yprev <= 1'b0;
                  r_zero  <= (io_bus.M1 == '0) || (io_bus.M2 == '0);
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            CALC: begin
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + 1'b1;
               r_yprev <= r_y[1];
               r_y     <= r_y >> 2;
               if (w_early) begin
                  r_res <= '0;
               end else if (w_last) begin
                  r_res <= w_acc_next[2*WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.RES  = r_res;
   assign io_bus.ACK  = (r_state == DONE);
   assign io_bus.BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_booth_r4_mul.sv
// Directed bench for booth_r4_mul: 24-bit instances with and without early zero, and an 8-bit instance.
// Expected products are hand-computed constants; latency and handshake timing are checked per vector.
module tb_booth_r4_mul;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int prev_cap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [23:0] m1_24, m2_24;
   logic        sgn_24, req_a, req_b, sel_b;
   logic [7:0]  m1_8, m2_8;
   logic        sgn_8, req_c;

   booth_r4_mul_if #(.WIDTH(24)) ifa ();
   booth_r4_mul_if #(.WIDTH(24)) ifb ();
   booth_r4_mul_if #(.WIDTH(8))  ifc ();

   assign ifa.M1 = m1_24;  assign ifa.M2 = m2_24;  assign ifa.SIGNED = sgn_24;  assign ifa.REQ = req_a;
   assign ifb.M1 = m1_24;  assign ifb.M2 = m2_24;  assign ifb.SIGNED = sgn_24;  assign ifb.REQ = req_b;
   assign ifc.M1 = m1_8;   assign ifc.M2 = m2_8;   assign ifc.SIGNED = sgn_8;   assign ifc.REQ = req_c;

   booth_r4_mul #(.WIDTH(24), .EARLY_ZERO(1'b1)) u_a (.CLK(clk), .RSTn(rst_n), .io_bus(ifa));
   booth_r4_mul #(.WIDTH(24), .EARLY_ZERO(1'b0)) u_b (.CLK(clk), .RSTn(rst_n), .io_bus(ifb));
   booth_r4_mul #(.WIDTH(8),  .EARLY_ZERO(1'b1)) u_c (.CLK(clk), .RSTn(rst_n), .io_bus(ifc));

   logic [47:0] res_24;
   logic        ack_24, busy_24;
   assign res_24  = sel_b ? ifb.RES  : ifa.RES;
   assign ack_24  = sel_b ? ifb.ACK  : ifa.ACK;
   assign busy_24 = sel_b ? ifb.BUSY : ifa.BUSY;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic run24(input string tag, input logic b, input logic [23:0] a, input logic [23:0] m,
                        input logic s, input logic [47:0] exp, input int exp_lat);
      int lat;
      sel_b = b; m1_24 = a; m2_24 = m; sgn_24 = s;
      if (b) req_b = 1'b1; else req_a = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".busy_cap"}, 64'(busy_24), 64'd1);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ack_24 && lat < 40);
      chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, ".res"}, 64'(res_24), 64'(exp));
      @(posedge clk); #1;
      chk({tag, ".ack_hold"}, 64'({ack_24, res_24}), 64'({1'b1, exp}));
      req_a = 1'b0; req_b = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".ack_busy_fall"}, 64'({ack_24, busy_24}), 64'd0);
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] m, input logic s,
                       input logic [15:0] exp, input logic b2b);
      int lat;
      m1_8 = a; m2_8 = m; sgn_8 = s; req_c = 1'b1;
      @(posedge clk); #1;
      if (b2b) chk({tag, ".period"}, 64'(cyc - prev_cap), 64'd7);
      prev_cap = cyc;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ifc.ACK && lat < 20);
      chk({tag, ".lat"}, 64'(lat), 64'd5);
      chk({tag, ".res"}, 64'(ifc.RES), 64'(exp));
      req_c = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".ack_fall"}, 64'(ifc.ACK), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      logic [15:0] seen;
      req_a = 0; req_b = 0; req_c = 0; sel_b = 0;
      m1_24 = '0; m2_24 = '0; sgn_24 = 0; m1_8 = '0; m2_8 = '0; sgn_8 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.a", 64'({ifa.ACK, ifa.BUSY, ifa.RES}), 64'd0);
      chk("reset.c", 64'({ifc.ACK, ifc.BUSY, ifc.RES}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run24("mant",       1'b0, 24'hB00000, 24'hB00000, 1'b0, 48'h790000000000, 13);
      run24("mode_s",     1'b0, 24'hFFFFFF, 24'h000003, 1'b1, 48'hFFFFFFFFFFFD, 13);
      run24("mode_u",     1'b0, 24'hFFFFFF, 24'h000003, 1'b0, 48'h000002FFFFFD, 13);
      run24("ext_s",      1'b0, 24'h800000, 24'h800000, 1'b1, 48'h400000000000, 13);
      run24("early0",     1'b0, 24'h000000, 24'h123456, 1'b0, 48'h0, 1);
      run24("ext_u",      1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 13);
      run24("mode_s_b",   1'b1, 24'hFFFFFF, 24'h000003, 1'b1, 48'hFFFFFFFFFFFD, 13);
      run24("noearly0",   1'b1, 24'h000000, 24'h123456, 1'b0, 48'h0, 13);

      // Reset in the middle of a calculation on instance A (RES currently nonzero).
      sel_b = 1'b0; m1_24 = 24'h123456; m2_24 = 24'h654321; sgn_24 = 1'b0; req_a = 1'b1;
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0; req_a = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid", 64'({ifa.ACK, ifa.BUSY, ifa.RES}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run24("rst_3x5",    1'b0, 24'd3, 24'd5, 1'b0, 48'd15, 13);

      run8("s_min_min",  8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
      run8("s_max_min",  8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1);
      run8("s_m1_1",     8'hFF, 8'h01, 1'b1, 16'hFFFF, 1'b1);
      run8("s_5_m3",     8'h05, 8'hFD, 1'b1, 16'hFFF1, 1'b1);
      run8("s_max_max",  8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1);
      run8("u_ff_ff",    8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
      run8("u_80_80",    8'h80, 8'h80, 1'b0, 16'h4000, 1'b1);
      run8("u_ff_1",     8'hFF, 8'h01, 1'b0, 16'h00FF, 1'b1);
      run8("u_12_13",    8'h0C, 8'h0D, 1'b0, 16'h009C, 1'b1);
      run8("u_aa_55",    8'hAA, 8'h55, 1'b0, 16'h3872, 1'b1);

      // REQ dropped mid-CALC: operation still completes, ACK is a one-cycle pulse.
      m1_8 = 8'hF6; m2_8 = 8'h07; sgn_8 = 1'b1; req_c = 1'b1;
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      req_c = 1'b0;
      ones = 0; seen = '0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (ifc.ACK) begin
            ones++;
            seen = ifc.RES;
         end
      end
      chk("drop.ack_cycles", 64'(ones), 64'd1);
      chk("drop.res", 64'(seen), 64'hFFBA);
      chk("drop.idle", 64'({ifc.ACK, ifc.BUSY}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
